sdio_data_xfer_seq: RTL and testbench



---
 rtl/sdio_data_xfer_seq_if.sv | 24 ++
 rtl/sdio_data_xfer_seq.sv | 158 +++++++++++++++
 tb/tb_sdio_data_xfer_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdio_data_xfer_seq_if.sv
// PHY-facing control bundle between the CMD53 data sequencer and the SDIO data PHY.
interface sdio_data_xfer_seq_if;
    logic       o_phy_activate;
    logic       o_phy_write_flag;
    logic [9:0] o_phy_data_count;
    logic       i_phy_finished;
    logic       i_phy_crc_good;

    modport master (
        output o_phy_activate,
        output o_phy_write_flag,
        output o_phy_data_count,
        input  i_phy_finished,
        input  i_phy_crc_good
    );

    modport slave (
        input  o_phy_activate,
        input  o_phy_write_flag,
        input  o_phy_data_count,
        output i_phy_finished,
        output i_phy_crc_good
    );
endinterface

// File: rtl/sdio_data_xfer_seq.sv
// CMD53 block/byte data transfer sequencer driving the SDIO data PHY on clk_x2.
module sdio_data_xfer_seq #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 9
) (
    input  logic             clk_x2,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_write,
    input  logic             i_block_mode,
    input  logic [9:0]       i_block_size,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_abort,
    sdio_data_xfer_seq_if.master phy,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_crc_err,
    output logic             o_timeout,
    output logic             o_aborted,
    output logic [CNT_W-1:0] o_blocks_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACTIVE, CHECK, GAP, FIN
    } state_t;

    state_t           state;
    logic             wr_q;
    logic             bm_q;
    logic [CNT_W-1:0] cnt_q;
    logic             crc_q;
    logic [TW-1:0]    tcnt;
    logic [GW-1:0]    gcnt;
    logic [9:0]       start_dc;
    logic             last_blk;

    // Out-of-range block sizes and a zero byte count both mean a full 512-byte block.
    always_comb begin
        start_dc = i_block_size;
        if (i_block_mode) begin
            if (i_block_size == 10'd0 || i_block_size > 10'd512)
                start_dc = 10'd512;
        end else begin
            if (i_count == '0)
                start_dc = 10'd512;
            else
                start_dc = 10'(i_count);
        end
    end

    always_comb begin
        last_blk = 1'b0;
        if (!bm_q)
            last_blk = 1'b1;
        else if (cnt_q != '0 && (o_blocks_done + 1'b1) == cnt_q)
            last_blk = 1'b1;
    end

    always_ff @(posedge clk_x2) begin
        if (rst) begin
            state                <= IDLE;
            wr_q                 <= 1'b0;
            bm_q                 <= 1'b0;
            cnt_q                <= '0;
            crc_q                <= 1'b0;
            tcnt                 <= '0;
            gcnt                 <= '0;
            phy.o_phy_activate   <= 1'b0;
            phy.o_phy_write_flag <= 1'b0;
            phy.o_phy_data_count <= '0;
            o_busy               <= 1'b0;
            o_done               <= 1'b0;
            o_crc_err            <= 1'b0;
            o_timeout            <= 1'b0;
            o_aborted            <= 1'b0;
            o_blocks_done        <= '0;
        end else begin
            o_done <= 1'b0;
            // Abort outranks finished/timeout; the block in flight is not counted.
            if (i_abort && state != IDLE && state != FIN) begin
                o_aborted          <= 1'b1;
                phy.o_phy_activate <= 1'b0;
                o_done             <= 1'b1;
                state              <= FIN;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start) begin
                            wr_q                 <= i_write;
                            bm_q                 <= i_block_mode;
                            cnt_q                <= i_count;
                            phy.o_phy_write_flag <= i_write;
                            phy.o_phy_data_count <= start_dc;
                            o_crc_err            <= 1'b0;
                            o_timeout            <= 1'b0;
                            o_aborted            <= 1'b0;
                            o_blocks_done        <= '0;
                            o_busy               <= 1'b1;
                            state                <= SETUP;
                        end
                    end
                    SETUP: begin
                        phy.o_phy_activate <= 1'b1;
                        tcnt               <= '0;
                        state              <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (phy.i_phy_finished) begin
                            crc_q              <= phy.i_phy_crc_good;
                            phy.o_phy_activate <= 1'b0;
                            state              <= CHECK;
                        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            o_timeout          <= 1'b1;
                            phy.o_phy_activate <= 1'b0;
                            o_done             <= 1'b1;
                            state              <= FIN;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (wr_q && !crc_q) begin
                            o_crc_err <= 1'b1;
                            o_done    <= 1'b1;
                            state     <= FIN;
                        end else begin
                            o_blocks_done <= o_blocks_done + 1'b1;
                            if (last_blk) begin
                                o_done <= 1'b1;
                                state  <= FIN;
                            end else begin
                                gcnt  <= '0;
                                state <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        // Long enough for the clk-domain PHY to see activate low.
                        if (gcnt == GW'(GAP_CYCLES - 1))
                            state <= SETUP;
                        else
                            gcnt <= gcnt + 1'b1;
                    end
                    FIN: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdio_data_xfer_seq.sv
// Scoreboard bench for sdio_data_xfer_seq with a behavioural data-PHY model.
module tb_sdio_data_xfer_seq;

    logic       clk_x2;
    logic       rst;
    logic       i_start;
    logic       i_write;
    logic       i_block_mode;
    logic [9:0] i_block_size;
    logic [8:0] i_count;
    logic       i_abort;
    logic       o_busy;
    logic       o_done;
    logic       o_crc_err;
    logic       o_timeout;
    logic       o_aborted;
    logic [8:0] o_blocks_done;

    sdio_data_xfer_seq_if pif ();

    sdio_data_xfer_seq #(
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(20),
        .CNT_W         (9)
    ) dut (
        .clk_x2       (clk_x2),
        .rst          (rst),
        .i_start      (i_start),
        .i_write      (i_write),
        .i_block_mode (i_block_mode),
        .i_block_size (i_block_size),
        .i_count      (i_count),
        .i_abort      (i_abort),
        .phy          (pif),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_crc_err    (o_crc_err),
        .o_timeout    (o_timeout),
        .o_aborted    (o_aborted),
        .o_blocks_done(o_blocks_done)
    );

    initial clk_x2 = 1'b0;
    always #5 clk_x2 = ~clk_x2;

    typedef struct {
        int blocks;
        bit crc;
        bit tmo;
        bit abt;
        int pulses;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int   errors  = 0;
    int   checks  = 0;
    int   pulses  = 0;
    int   low_run = 0;
    int   dly     = 0;
    int   phy_dly = 5;
    int   bad_at  = 0;
    bit   hang    = 0;
    bit   prev_act = 0;
    bit   exp_wf  = 0;
    logic [9:0] exp_dc = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor first, then the PHY model, so both see the same activate sample.
    always @(negedge clk_x2) begin
        if (rst) begin
            pif.i_phy_finished = 1'b0;
            pif.i_phy_crc_good = 1'b0;
            dly      = 0;
            prev_act = 1'b0;
        end else begin
            if (pif.o_phy_activate && !prev_act) begin
                if (pulses > 0)
                    chk("gap_low", 32'(low_run >= 4), 1);
                chk("wflag", 32'(pif.o_phy_write_flag), 32'(exp_wf));
                chk("dcount", 32'(pif.o_phy_data_count), 32'(exp_dc));
                pulses++;
                low_run = 0;
            end
            if (!pif.o_phy_activate)
                low_run++;
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("blocks", 32'(o_blocks_done), 32'(e_mon.blocks));
                    chk("crc_err", 32'(o_crc_err), 32'(e_mon.crc));
                    chk("timeout", 32'(o_timeout), 32'(e_mon.tmo));
                    chk("aborted", 32'(o_aborted), 32'(e_mon.abt));
                    chk("pulses", 32'(pulses), 32'(e_mon.pulses));
                    chk("act_at_done", 32'(pif.o_phy_activate), 0);
                end
            end
            prev_act = pif.o_phy_activate;
            if (!pif.o_phy_activate) begin
                pif.i_phy_finished = 1'b0;
                dly = 0;
            end else if (!pif.i_phy_finished && !hang) begin
                dly++;
                if (dly >= phy_dly) begin
                    pif.i_phy_finished = 1'b1;
                    pif.i_phy_crc_good = (pulses != bad_at);
                end
            end
        end
    end

    task automatic start_xfer(bit wr, bit bm, logic [9:0] sz, logic [8:0] cnt,
                              logic [9:0] edc, int eblk, bit ecrc, bit etmo,
                              bit eabt, int epul);
        exp_t e;
        @(negedge clk_x2);
        e.blocks = eblk;
        e.crc    = ecrc;
        e.tmo    = etmo;
        e.abt    = eabt;
        e.pulses = epul;
        sb.push_back(e);
        exp_wf       = wr;
        exp_dc       = edc;
        pulses       = 0;
        low_run      = 0;
        i_write      = wr;
        i_block_mode = bm;
        i_block_size = sz;
        i_count      = cnt;
        i_start      = 1'b1;
        @(negedge clk_x2);
        i_start = 1'b0;
        chk("busy_start", 32'(o_busy), 1);
        chk("flags_clr", 32'({o_crc_err, o_timeout, o_aborted}), 0);
        chk("blk_clr", 32'(o_blocks_done), 0);
        chk("act_setup", 32'(pif.o_phy_activate), 0);
        @(negedge clk_x2);
        chk("act_rise", 32'(pif.o_phy_activate), 1);
    endtask

    task automatic wait_idle(int maxc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk_x2);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_wait", 0, 1);
            sb.delete();
        end
        @(negedge clk_x2);
        chk("busy_end", 32'(o_busy), 0);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_write      = 1'b0;
        i_block_mode = 1'b0;
        i_block_size = '0;
        i_count      = '0;
        i_abort      = 1'b0;
        pif.i_phy_finished = 1'b0;
        pif.i_phy_crc_good = 1'b0;
        repeat (3) @(negedge clk_x2);
        chk("rst_act", 32'(pif.o_phy_activate), 0);
        chk("rst_wf", 32'(pif.o_phy_write_flag), 0);
        chk("rst_dc", 32'(pif.o_phy_data_count), 0);
        chk("rst_stat", 32'({o_busy, o_done, o_crc_err, o_timeout, o_aborted}), 0);
        chk("rst_blk", 32'(o_blocks_done), 0);
        rst = 1'b0;

        // Abort while idle must be ignored.
        i_abort = 1'b1;
        @(negedge clk_x2);
        i_abort = 1'b0;
        chk("idle_abort", 32'({o_busy, o_aborted, o_done}), 0);

        // Block write x3; a second start mid-transfer must be ignored.
        start_xfer(1, 1, 10'd512, 9'd3, 10'd512, 3, 0, 0, 0, 3);
        repeat (4) @(negedge clk_x2);
        i_write = 1'b0;
        i_count = 9'd1;
        i_start = 1'b1;
        @(negedge clk_x2);
        i_start = 1'b0;
        chk("busy_ignore", 32'(o_busy), 1);
        chk("flags_ignore", 32'({o_crc_err, o_timeout, o_aborted}), 0);
        wait_idle(400);

        // Byte-mode read, count 0 means 512 bytes.
        start_xfer(0, 0, 10'd100, 9'd0, 10'd512, 1, 0, 0, 0, 1);
        wait_idle(200);

        // Write CRC failure on block 2 of 4.
        bad_at = 2;
        start_xfer(1, 1, 10'd128, 9'd4, 10'd128, 1, 1, 0, 0, 2);
        wait_idle(400);
        bad_at = 0;

        // Infinite read aborted during block 6.
        start_xfer(0, 1, 10'd64, 9'd0, 10'd64, 5, 0, 0, 1, 6);
        n = 0;
        while (!(pulses == 6 && pif.o_phy_activate) && n < 500) begin
            @(negedge clk_x2);
            n++;
        end
        chk("abort_reach", 32'(pulses == 6 && pif.o_phy_activate), 1);
        @(negedge clk_x2);
        i_abort = 1'b1;
        @(negedge clk_x2);
        i_abort = 1'b0;
        chk("abort_act", 32'(pif.o_phy_activate), 0);
        chk("abort_flag", 32'(o_aborted), 1);
        wait_idle(50);

        // PHY never finishes: activate held exactly TIMEOUT_CYCLES.
        hang = 1;
        start_xfer(1, 1, 10'd16, 9'd1, 10'd16, 0, 0, 1, 0, 1);
        n = 1;
        while (pif.o_phy_activate && n < 100) begin
            @(negedge clk_x2);
            if (pif.o_phy_activate)
                n++;
        end
        chk("tmo_len", 32'(n), 20);
        hang = 0;
        wait_idle(50);

        // Reset in the gap after block 2; no done pulse may follow.
        start_xfer(1, 1, 10'd600, 9'd3, 10'd512, 3, 0, 0, 0, 3);
        n = 0;
        while (!(o_blocks_done == 9'd2 && !pif.o_phy_activate) && n < 400) begin
            @(negedge clk_x2);
            n++;
        end
        chk("gap_reach", 32'(o_blocks_done), 2);
        sb.delete();
        rst = 1'b1;
        @(negedge clk_x2);
        rst = 1'b0;
        chk("mrst_act", 32'(pif.o_phy_activate), 0);
        chk("mrst_stat", 32'({o_busy, o_done, o_crc_err, o_timeout, o_aborted}), 0);
        chk("mrst_blk", 32'(o_blocks_done), 0);
        repeat (20) @(negedge clk_x2);
        chk("mrst_idle", 32'({o_busy, pif.o_phy_activate}), 0);

        start_xfer(0, 1, 10'd32, 9'd2, 10'd32, 2, 0, 0, 0, 2);
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
